// File: rtl/serial_rx_ctrl.sv
// rtl/serial_rx_ctrl.sv - asynchronous serial frame receiver with ready/read handshake
module serial_rx_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 rx_busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW       = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP,
        LOAD
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_sync1;
    logic                   r_sync;
    logic                   r_prev;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic                   r_stop_bit;
    logic                   w_start_edge;
    logic                   w_sample;
    logic                   w_state_change;

    assign w_start_edge   = r_prev & ~r_sync;
    assign w_state_change = (w_next_state != r_state);
    assign rx_busy        = (r_state != IDLE);

    // Sample point: half a bit into the start bit, then one full bit per data/stop bit.
    always_comb begin
        w_sample = 1'b0;
        case (r_state)
            START_CHK:   w_sample = (r_cnt == HALF_LAST);
            DATA, STOP:  w_sample = (r_cnt == BIT_LAST);
            default:     w_sample = 1'b0;
        endcase
    end

    // Shift right, new sample enters the MSB so the first bit ends up in the LSB.
    always_comb begin
        w_shift_next                = r_shift >> 1;
        w_shift_next[DATA_BITS-1]   = r_sync;
    end

    // Next-state logic for the frame FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_start_edge) w_next_state = START_CHK;
            START_CHK: if (w_sample) w_next_state = r_sync ? IDLE : DATA;
            DATA:      if (w_sample && (r_idx == IDX_LAST)) w_next_state = STOP;
            STOP:      if (w_sample) w_next_state = LOAD;
            LOAD:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // State register, line synchronizer, timing counters and shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_sync1    <= 1'b1;
            r_sync     <= 1'b1;
            r_prev     <= 1'b1;
            r_shift    <= '1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_stop_bit <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_sync1 <= serial_in;
            r_sync  <= r_sync1;
            r_prev  <= r_sync;
            if (w_state_change || w_sample || (r_state == IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_state_change)
                r_idx <= '0;
            else if ((r_state == DATA) && w_sample)
                r_idx <= r_idx + 1'b1;
            if ((r_state == DATA) && w_sample)
                r_shift <= w_shift_next;
            if ((r_state == STOP) && w_sample)
                r_stop_bit <= r_sync;
        end
    end

    // Consumer-facing outputs: frame delivery on LOAD, otherwise read handshake.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else if (r_state == LOAD) begin
            if (r_stop_bit) begin
                rx_data       <= r_shift;
                data_ready    <= 1'b1;
                framing_error <= 1'b0;
                overrun_error <= data_ready & ~data_read;
            end else begin
                framing_error <= 1'b1;
            end
        end else begin
            if ((r_state == IDLE) && w_start_edge)
                framing_error <= 1'b0;
            if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_rx_ctrl.sv
// tb/tb_serial_rx_ctrl.sv - directed scoreboard bench for serial_rx_ctrl
module tb_serial_rx_ctrl;
    localparam int DB  = 8;
    localparam int CPB = 10;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          serial_in = 1'b1;
    logic          data_read = 1'b0;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;
    logic          rx_busy;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DB-1:0] exp_q[$];
    int            busy_cnt;

    always #5 clk = ~clk;

    serial_rx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag);
        logic [DB-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, rx_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, 16'(rx_data), 16'(e));
        end
    endtask

    // Drives one frame starting at a negedge; the next posedge is edge k.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            serial_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_data", 16'(rx_data), 16'h0);
        check("rst_ready", 16'(data_ready), 16'h0);
        check("rst_overrun", 16'(overrun_error), 16'h0);
        check("rst_framing", 16'(framing_error), 16'h0);
        check("rst_busy", 16'(rx_busy), 16'h0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: frame 0xA5, exact delivery latency
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (98) @(posedge clk);
                #1 check("t1_not_ready_k97", 16'(data_ready), 16'h0);
                @(posedge clk);
                #1 check("t1_ready_k98", 16'(data_ready), 16'h1);
                check_rx("t1_rx_data");
                check("t1_framing", 16'(framing_error), 16'h0);
                check("t1_overrun", 16'(overrun_error), 16'h0);
            end
        join
        repeat (3) @(negedge clk);

        // 2: read handshake
        pulse_read();
        check("t2_ready_clr", 16'(data_ready), 16'h0);
        check("t2_rx_hold", 16'(rx_data), 16'hA5);
        repeat (3) @(negedge clk);

        // 3: overrun
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        check_rx("t3_rx_first");
        check("t3_ovr_first", 16'(overrun_error), 16'h0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        check_rx("t3_rx_second");
        check("t3_ready", 16'(data_ready), 16'h1);
        check("t3_overrun", 16'(overrun_error), 16'h1);
        pulse_read();
        check("t3_ready_clr", 16'(data_ready), 16'h0);
        check("t3_ovr_clr", 16'(overrun_error), 16'h0);
        repeat (3) @(negedge clk);

        // 4: framing error then recovery
        send_frame(8'h55, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_framing", 16'(framing_error), 16'h1);
        check("t4_ready_hold", 16'(data_ready), 16'h0);
        check("t4_rx_hold", 16'(rx_data), 16'hC3);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        check("t4_framing_clr", 16'(framing_error), 16'h0);
        check_rx("t4_rx_good");
        check("t4_ready", 16'(data_ready), 16'h1);

        // 5: 3-clock glitch is a false start
        busy_cnt = 0;
        serial_in = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) serial_in = 1'b1;
            @(negedge clk);
            if (rx_busy) busy_cnt++;
        end
        check("t5_busy_cycles", 16'(busy_cnt), 16'd5);
        check("t5_busy_end", 16'(rx_busy), 16'h0);
        check("t5_rx_hold", 16'(rx_data), 16'h0F);
        check("t5_ready_hold", 16'(data_ready), 16'h1);
        check("t5_framing_hold", 16'(framing_error), 16'h0);

        // 6: reset mid-frame, then a clean frame
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (51) @(posedge clk);
                @(negedge clk);
                check("t6_busy_mid", 16'(rx_busy), 16'h1);
                n_rst = 1'b0;
                #1;
                check("t6_rst_rx", 16'(rx_data), 16'h0);
                check("t6_rst_ready", 16'(data_ready), 16'h0);
                check("t6_rst_busy", 16'(rx_busy), 16'h0);
                repeat (2) @(negedge clk);
                n_rst = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("t6_idle_after", 16'(rx_busy), 16'h0);
        check("t6_no_ready", 16'(data_ready), 16'h0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (3) @(negedge clk);
        check_rx("t6_rx_81");
        check("t6_ready", 16'(data_ready), 16'h1);
        check("t6_framing", 16'(framing_error), 16'h0);
        check("t6_overrun", 16'(overrun_error), 16'h0);
        check("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
